// File: rtl/e1_pkg.sv
// e1_pkg: shared E1 framing constants and slot/frame index types
package e1_pkg;
  localparam int E1_TS_PER_FRAME = 32;
  localparam int E1_FRAMES_PER_MF = 16;
  localparam logic [7:0] E1_IDLE_OCTET = 8'hFF;
  typedef logic [4:0] ts_t;
  typedef logic [3:0] frame_t;
endpackage

// File: rtl/e1_tx_nco.sv
// e1_tx_nco: fractional NCO producing a bit strobe averaging RATE_NUM/RATE_DEN per clk
module e1_tx_nco #(
  parameter int RATE_NUM = 32,
  parameter int RATE_DEN = 480
) (
  input  logic clk,
  input  logic rst_n,
  output logic strobe
);
  localparam int AW = $clog2(RATE_DEN) + 1;
  logic [AW-1:0] acc, sum;
  assign sum = acc + AW'(RATE_NUM);
  assign strobe = sum >= AW'(RATE_DEN);
  // phase accumulator, folded back by the modulus on every strobe
  always_ff @(posedge clk)
    if (!rst_n) acc <= '0;
    else acc <= strobe ? sum - AW'(RATE_DEN) : sum;
endmodule

// File: rtl/e1_tx_octet_serializer.sv
// e1_tx_octet_serializer: MSB-first octet serializer with holding register and timeslot/multiframe tracking
module e1_tx_octet_serializer
  import e1_pkg::*;
#(
  parameter int RATE_NUM = 32,
  parameter int RATE_DEN = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output ts_t        in_ts,
  output frame_t     in_frame,
  output logic       out_data,
  output logic       out_valid,
  output logic       underrun
);
  logic bit_stb, reload, hold_full;
  logic [7:0] shreg, hold;
  logic [2:0] bit_cnt;
  ts_t ts_cur;
  frame_t frame_cur;
  e1_tx_nco #(.RATE_NUM(RATE_NUM), .RATE_DEN(RATE_DEN)) u_nco (
    .clk(clk),
    .rst_n(rst_n),
    .strobe(bit_stb)
  );
  assign reload = bit_stb && bit_cnt == 3'd7;
  assign in_ready = !hold_full;
  assign in_ts = ts_cur + 5'd1;
  assign in_frame = &ts_cur ? frame_cur + 4'd1 : frame_cur;
  // shift out on each strobe; a reload takes the held octet or idles with an underrun pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      shreg <= E1_IDLE_OCTET;
      hold <= '0;
      hold_full <= 1'b0;
      bit_cnt <= '0;
      ts_cur <= '0;
      frame_cur <= '0;
      out_data <= 1'b1;
      out_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      out_valid <= bit_stb;
      underrun <= reload && !hold_full;
      if (bit_stb) begin
        out_data <= shreg[7];
        bit_cnt <= bit_cnt + 3'd1;
        shreg <= reload ? (hold_full ? hold : E1_IDLE_OCTET) : shreg << 1;
      end
      if (reload) begin
        ts_cur <= ts_cur + 5'd1;
        if (&ts_cur) frame_cur <= frame_cur + 4'd1;
      end
      if (in_valid && in_ready) begin
        hold <= in_data;
        hold_full <= 1'b1;
      end else if (reload) hold_full <= 1'b0;
    end
endmodule

// File: tb/tb_e1_tx_octet_serializer.sv
// tb_e1_tx_octet_serializer: scoreboard bench with a cycle-arithmetic reference of slot timing
module tb_e1_tx_octet_serializer;
  localparam int SLOT = 120;
  localparam int N = 61740;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_data, out_valid, underrun;
  logic [4:0] in_ts;
  logic [3:0] in_frame;
  logic rst2_n = 0, v2 = 0;
  logic [7:0] d2 = 0;
  logic r2, od2, ov2, ur2;
  logic [4:0] ts2;
  logic [3:0] fr2;
  int checks = 0, errors = 0, cyc = 0, pulses = 0, cnt2 = 0;
  bit mon_on = 0, done2 = 0, taken = 0;
  typedef struct {logic b; int c;} exp_t;
  exp_t bq[$];
  exp_t mon_e;
  int uq[$];
  logic [8:0] slot_v [0:1023];

  e1_tx_octet_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_ts(in_ts), .in_frame(in_frame), .out_data(out_data), .out_valid(out_valid), .underrun(underrun)
  );
  e1_tx_octet_serializer #(.RATE_NUM(3), .RATE_DEN(47)) u2 (
    .clk(clk), .rst_n(rst2_n), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .in_ts(ts2), .in_frame(fr2), .out_data(od2), .out_valid(ov2), .underrun(ur2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // slot m starts at the reload in cycle SLOT*m; bit i leaves one cycle after strobe 15*(i+1) later
  task automatic push_slot(input int m, input logic [7:0] o);
    for (int i = 0; i < 8; i++) bq.push_back('{o[7-i], SLOT*m + 15*(i+1) + 1});
  endtask

  always @(negedge clk) if (mon_on) begin
    while (bq.size() > 0 && bq[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL bit_missing cycle=%0d actual=none required_cycle=%0d", cyc, bq[0].c);
      void'(bq.pop_front());
    end
    while (uq.size() > 0 && uq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL underrun_missing cycle=%0d actual=none required_cycle=%0d", cyc, uq[0]);
      void'(uq.pop_front());
    end
    if (out_valid) begin
      if (cyc <= 4801) pulses++;
      if (bq.size() == 0) chk("bit_unexpected", 1, 0);
      else begin
        mon_e = bq.pop_front();
        chk("bit_time", cyc, mon_e.c);
        chk("bit_value", int'(out_data), int'(mon_e.b));
      end
    end
    if (underrun) begin
      if (uq.size() == 0) chk("underrun_unexpected", 1, 0);
      else chk("underrun_time", cyc, uq.pop_front());
    end
  end

  initial begin
    int n, tgt;
    bit mready;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    in_valid = 1;
    in_data = 8'h00;
    for (int c = 1; c <= 182; c++) begin
      cyc = c;
      if (c == 182) begin
        @(negedge clk);
        chk("pre_reset_out_data", int'(out_data), 0);
      end
      @(posedge clk);
    end
    #1 rst_n = 0;
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 1024; i++) slot_v[i] = '0;
    push_slot(0, 8'hFF);
    cyc = 1;
    mon_on = 1;
    for (int c = 1; c <= N; c++) begin
      cyc = c;
      if (taken) in_valid = 0;
      taken = 0;
      if (c < 400) begin
        in_valid = 1;
        in_data = 8'hA5;
      end else if (c >= 1200 && c < 1680) in_valid = 0;
      else if (c == 1680) begin
        in_valid = 1;
        in_data = 8'h5A;
      end else if (!in_valid) begin
        if (c < 1200) begin
          in_valid = $urandom_range(1) == 1;
          in_data = 8'($urandom);
        end else begin
          in_valid = $urandom_range(7) != 0;
          in_data = 8'(c / SLOT + 1);
        end
      end
      n = (c - 1) / SLOT;
      mready = !slot_v[(c + SLOT - 1) / SLOT][8];
      tgt = c / SLOT + 1;
      @(negedge clk);
      if (c == 1) begin
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 1);
        chk("reset_underrun", int'(underrun), 0);
      end
      chk("in_ready", int'(in_ready), int'(mready));
      if (mready) begin
        chk("in_ts", int'(in_ts), (n + 1) % 32);
        chk("in_frame", int'(in_frame), ((n + 1) / 32) % 16);
      end
      @(posedge clk);
      if (in_valid && mready) begin
        slot_v[tgt] = {1'b1, in_data};
        taken = 1;
      end
      if (c % SLOT == 0) begin
        if (slot_v[c / SLOT][8]) push_slot(c / SLOT, slot_v[c / SLOT][7:0]);
        else begin
          push_slot(c / SLOT, 8'hFF);
          uq.push_back(c + 1);
        end
      end
      #1;
    end
    mon_on = 0;
    chk("pulses_in_4800", pulses, 320);
    chk("bits_drained", int'(bq.size() == 0 || bq[0].c > N), 1);
    chk("underruns_drained", int'(uq.size() == 0 || uq[0] > N), 1);
    chk("rate_3_47_done", int'(done2), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit want;
    repeat (2) @(posedge clk);
    #1 rst2_n = 1;
    for (int k = 1; k <= 471; k++) begin
      @(negedge clk);
      want = k >= 2 && ((k - 1) * 3 / 47 != (k - 2) * 3 / 47);
      chk("rate_3_47_strobe", int'(ov2), int'(want));
      if (ov2) cnt2++;
      @(posedge clk);
      #1;
    end
    chk("rate_3_47_count", cnt2, 30);
    done2 = 1;
  end
endmodule

// File: doc/e1_tx_octet_serializer.md
Name: e1_tx_octet_serializer

Overview:
- Sits directly upstream of the external-LIU TX interface.
- Accepts timeslot octets from the TX framer over a valid/ready handshake and serializes them MSB first.
- Emits one-cycle out_data/out_valid bit strobes at the E1 line rate (2.048 Mbit/s). The rate comes from a fractional NCO running on the system clock.
- Tracks the timeslot and multiframe position so the framer knows which slot its next octet fills.

Parameters:
- RATE_NUM, 32: NCO increment numerator; line rate = f_clk * RATE_NUM / RATE_DEN.
- RATE_DEN, 480: NCO modulus. The defaults give 1 bit per 15 clk at 30.72 MHz. Must satisfy RATE_NUM < RATE_DEN.

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- in_data  in  8  octet for the next timeslot
- in_valid  in  1  in_data valid
- in_ready  out  1  holding register empty; transfer occurs when in_valid & in_ready
- in_ts  out  5  timeslot (0..31) that an octet accepted this cycle will occupy
- in_frame  out  4  frame (0..15) within the multiframe for that octet
- out_data  out  1  serial bit, MSB of each octet first
- out_valid  out  1  one-cycle strobe per line bit
- underrun  out  1  one-cycle pulse when a reload found the holding register empty

Behaviour:
- Reset (rst_n low at a clk edge, synchronous; all state, including mid-octet, is discarded):
  - acc = 0, shreg = 8'hFF, bit_cnt = 0, ts_cur = 0, frame_cur = 0, hold_full = 0.
  - out_data = 1, out_valid = 0, underrun = 0.
- NCO:
  - Accumulator width is clog2(RATE_DEN)+1 bits; the sum acc+RATE_NUM must not overflow.
  - Each cycle: if acc+RATE_NUM >= RATE_DEN, then acc <= acc+RATE_NUM-RATE_DEN and bit_stb = 1; else acc <= acc+RATE_NUM and bit_stb = 0.
  - bit_stb is combinational from acc; its period averages RATE_DEN/RATE_NUM clk. With the defaults it is exactly every 15 clk.
  - First bit_stb after reset occurs in the 15th cycle after reset release.
- Serializer, on bit_stb:
  - out_data <= shreg[7] and out_valid <= 1 for exactly one cycle. Latency is one clk after bit_stb.
  - If bit_cnt != 7: shreg <= shreg << 1 and bit_cnt++.
  - If bit_cnt == 7 (reload):
    - bit_cnt <= 0.
    - shreg <= hold if hold_full, else 8'hFF with underrun pulsed for one cycle.
    - hold_full <= 0.
    - ts_cur <= ts_cur+1 mod 32. On the wrap 31->0, frame_cur <= frame_cur+1 mod 16.
  - out_data holds its value between strobes.
- Holding register:
  - in_ready = !hold_full. This is a registered-state function with no combinational path from in_valid.
  - Accept (in_valid & in_ready): hold <= in_data, hold_full <= 1.
- Accept coinciding with reload while hold is empty:
  - The reload takes 8'hFF and pulses underrun.
  - The accepted octet lands in hold and is used at the next reload.
  - No bypass.
- in_ts/in_frame:
  - Equal ts_cur+1 mod 32, with frame_cur, or frame_cur+1 mod 16 when ts_cur == 31.
  - Values are combinational from current state.
  - They are meaningful only while in_ready = 1. In a reload cycle they still reflect the pre-update state, consistent with the no-bypass rule above.
- Octet timing:
  - Slot 0 of frame 0 after reset transmits the reset preload 8'hFF. This is not flagged as underrun.
  - The first upstream octet fills ts 1 / frame 0.
- Throughput and stalling:
  - At most one octet is consumed per 8 bit strobes.
  - The upstream may hold in_valid indefinitely. in_data must stay stable until accepted.

Decomposition:
- Shared package e1_pkg:
  - E1_TS_PER_FRAME = 32, E1_FRAMES_PER_MF = 16, E1_IDLE_OCTET = 8'hFF.
  - Type aliases ts_t (5 bits) and frame_t (4 bits).
- Sub-module e1_tx_nco (parameters RATE_NUM/RATE_DEN; ports clk, rst_n, strobe out). It is reusable for the RX recovery path.
- The serializer, counters and holding register stay in this block.

Test Plan:
- Rate: defaults, free-running for 4800 clk after reset -> exactly 320 out_valid pulses, each spaced 15 clk. RATE_NUM=3/RATE_DEN=47 -> 3 pulses per 47 clk over 470 clk.
- Ordering: in_data 8'hA5 offered continuously from reset -> ts 1 bits 1,0,1,0,0,1,0,1. in_ready low from accept until the ts-1 reload.
- Underrun: in_valid held low after one octet -> the next reload sends 8'hFF (eight 1s) with underrun high for exactly 1 clk.
- Counters: stream octets = slot number -> after 32 reloads in_ts wraps 31->0 and in_frame goes 0->1. After 512 reloads in_frame wraps 15->0.
- Race: in_valid rises in the exact reload cycle with hold empty -> underrun pulses, the slot carries 8'hFF, and the octet appears in the following slot.
- Reset mid-octet: assert rst_n=0 for 1 clk after bit 3 of a slot -> out_valid=0, out_data=1, in_ready=1, in_ts=1, in_frame=0. The next strobe arrives 15 clk after release.
